// File: rtl/uart_tx_mmio_if.sv
// Valid/ready MMIO slot between the address arbiter and the UART transmitter.
interface uart_tx_mmio_if;
  logic        valid;
  logic        ready;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;

  modport master (output valid, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/uart_tx_mmio.sv
// MMIO UART transmitter: CPU writes bytes into a small FIFO that a TX FSM
// serialises as 8N1 frames; a STATUS register exposes busy/full/empty/count.
module uart_tx_mmio #(
  parameter int unsigned CLK_DIV    = 868,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_mmio_if.slave  bus,
  output logic           uart_tx
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned DIV_W = $clog2(CLK_DIV);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [2:0]          bit_q, bit_d;
  logic [7:0]          shift_q, shift_d;
  logic                tx_q, tx_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [7:0]          mem_q [FIFO_DEPTH];

  logic                full_c, empty_c, accept_c, push_c, pop_c, div_last_c;
  logic                is_write_c, stall_c;
  logic [1:0]          off_c;
  logic [31:0]         status_c;
  logic                unused_c;

  assign unused_c = ^{bus.addr[31:4], bus.addr[1:0], bus.wdata[31:8]};

  // Bus decode, FIFO bookkeeping and register read-back.
  always_comb begin
    full_c     = (count_q == CNT_W'(FIFO_DEPTH));
    empty_c    = (count_q == '0);
    off_c      = bus.addr[3:2];
    is_write_c = |bus.wstrb;

    status_c             = '0;
    status_c[0]          = (state_q != S_IDLE) || !empty_c;
    status_c[1]          = full_c;
    status_c[2]          = empty_c;
    status_c[8 +: CNT_W] = count_q;

    // done_q blocks re-acceptance of a request whose valid has not dropped yet.
    stall_c  = (off_c == 2'd0) && bus.wstrb[0] && full_c;
    accept_c = bus.valid && !ready_q && !done_q && !stall_c;
    push_c   = accept_c && (off_c == 2'd0) && bus.wstrb[0];
    pop_c    = (state_q == S_IDLE) && !empty_c;

    ready_d = accept_c;
    done_d  = done_q;
    if (accept_c)       done_d = 1'b1;
    else if (!bus.valid) done_d = 1'b0;

    rdata_d = '0;
    if (accept_c && !is_write_c && (off_c == 2'd1)) rdata_d = status_c;

    wr_ptr_d = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_c  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // TX FSM; uart_tx is registered from the current state, so it lags one cycle.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    tx_d       = 1'b1;
    div_last_c = (div_q == DIV_W'(CLK_DIV - 1));

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (pop_c) begin
          shift_d = mem_q[rd_ptr_q];
          div_d   = '0;
          bit_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (div_last_c) begin
          div_d   = '0;
          state_d = S_DATA;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_DATA: begin
        tx_d = shift_q[0];
        if (div_last_c) begin
          div_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (div_last_c) begin
          div_d   = '0;
          state_d = S_IDLE;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
    end
  end

  // FIFO storage needs no reset; pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= bus.wdata[7:0];
  end

  assign bus.ready = ready_q;
  assign bus.rdata = rdata_q;
  assign uart_tx   = tx_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: bus accesses plus a serial-line decoder.
module tb_uart_tx_mmio;

  localparam int unsigned CD      = 4;
  localparam int unsigned DEPTH   = 8;
  localparam int          LAT_MAX = 12 * CD + 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart_tx;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  uart_tx_mmio_if bus ();

  uart_tx_mmio #(.CLK_DIV(CD), .FIFO_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .uart_tx (uart_tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Serial decoder: mid-bit sampling, records each byte and its start cycle.
  logic [7:0] rx_q[$];
  int         rx_t[$];
  bit         mon_active = 1'b0;
  int         mon_start = 0;
  int         mon_off;
  logic [7:0] mon_byte;
  int         framing_err = 0;

  always @(negedge clk) begin
    if (rst) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (uart_tx === 1'b0) begin
        mon_active = 1'b1;
        mon_start  = cyc;
        mon_byte   = '0;
      end
    end else begin
      mon_off = cyc - mon_start;
      for (int k = 1; k <= 8; k++)
        if (mon_off == k * int'(CD) + int'(CD) / 2) mon_byte[k-1] = uart_tx;
      if (mon_off == 9 * int'(CD) + int'(CD) / 2) begin
        if (uart_tx !== 1'b1) framing_err++;
        rx_q.push_back(mon_byte);
        rx_t.push_back(mon_start);
        mon_active = 1'b0;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_access(input logic [1:0] off, input logic [31:0] wd,
                           input logic [3:0] ws, output logic [31:0] rd, output int lat);
    bus.valid = 1'b1;
    bus.addr  = {28'h0, off, 2'b00};
    bus.wdata = wd;
    bus.wstrb = ws;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (bus.ready !== 1'b1 && lat < LAT_MAX);
    checks++;
    if (bus.ready !== 1'b1) begin
      failures++;
      $display("FAIL access_timeout off=%0d ready=%b required 1 within %0d cycles", off, bus.ready, LAT_MAX);
    end
    rd = bus.rdata;
    bus.valid = 1'b0;
    bus.wstrb = '0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    int lat;
    rst = 1'b1;
    idle(2);
    checks++; if (bus.ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", bus.ready); end
    checks++; if (bus.rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", bus.rdata); end
    checks++; if (uart_tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", uart_tx); end
    rst = 1'b0;
    idle(1);
    do_access(2'd1, 32'h0, 4'h0, rd, lat);
    checks++; if (rd !== 32'h4) begin failures++; $display("FAIL reset_status got=%h exp=00000004", rd); end
    idle(1);
  endtask

  task automatic test_single_byte();
    logic [31:0] rd;
    logic [9:0]  pat;
    int lat;
    rx_q.delete(); rx_t.delete();
    pat = {1'b1, 8'h55, 1'b0};
    do_access(2'd0, 32'h55, 4'h1, rd, lat);
    checks++; if (lat !== 1) begin failures++; $display("FAIL single_latency got=%0d exp=1", lat); end
    idle(1);
    checks++; if (uart_tx !== 1'b1) begin failures++; $display("FAIL single_pre_start got=%b exp=1", uart_tx); end
    for (int b = 0; b < 10; b++)
      for (int c = 0; c < int'(CD); c++) begin
        idle(1);
        checks++;
        if (uart_tx !== pat[b]) begin
          failures++;
          $display("FAIL single_bit%0d_cyc%0d got=%b exp=%b", b, c, uart_tx, pat[b]);
        end
      end
    for (int c = 0; c < 3; c++) begin
      idle(1);
      checks++; if (uart_tx !== 1'b1) begin failures++; $display("FAIL single_idle_high got=%b exp=1", uart_tx); end
    end
    do_access(2'd1, 32'h0, 4'h0, rd, lat);
    checks++; if (rd !== 32'h4) begin failures++; $display("FAIL single_status got=%h exp=00000004", rd); end
    checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'h55) begin failures++; $display("FAIL single_rx size=%0d exp 1 byte 55", rx_q.size()); end
    idle(1);
  endtask

  task automatic test_status_during_tx();
    logic [31:0] rd;
    int lat;
    rx_q.delete(); rx_t.delete();
    do_access(2'd0, 32'hA3, 4'h1, rd, lat);
    idle(1);
    do_access(2'd1, 32'h0, 4'h0, rd, lat);
    checks++; if (rd !== 32'h5) begin failures++; $display("FAIL status_busy got=%h exp=00000005", rd); end
    idle(10 * CD + 6);
    checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'hA3) begin failures++; $display("FAIL status_rx size=%0d exp 1 byte a3", rx_q.size()); end
  endtask

  task automatic test_fifo_full();
    logic [31:0] rd;
    int lat [10];
    int l;
    rx_q.delete(); rx_t.delete();
    framing_err = 0;
    for (int i = 0; i < 10; i++) begin
      do_access(2'd0, 32'(i), 4'h1, rd, lat[i]);
      idle(1);
      if (i == 8) begin
        do_access(2'd1, 32'h0, 4'h0, rd, l);
        checks++; if (rd !== 32'h803) begin failures++; $display("FAIL full_status got=%h exp=00000803", rd); end
        idle(1);
      end
    end
    for (int i = 0; i < 9; i++) begin
      checks++; if (lat[i] != 1) begin failures++; $display("FAIL full_lat%0d got=%0d exp=1", i, lat[i]); end
    end
    checks++; if (lat[9] <= 1) begin failures++; $display("FAIL full_stall got=%0d exp>1", lat[9]); end
    idle(10 * (10 * CD + 1) + 20);
    checks++; if (rx_q.size() != 10) begin failures++; $display("FAIL full_rx_count got=%0d exp=10", rx_q.size()); end
    for (int i = 0; i < 10 && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== 8'(i)) begin failures++; $display("FAIL full_rx%0d got=%h exp=%h", i, rx_q[i], 8'(i)); end
    end
    for (int i = 1; i < 10 && i < rx_t.size(); i++) begin
      checks++;
      if (rx_t[i] - rx_t[i-1] != 10 * int'(CD) + 1) begin
        failures++;
        $display("FAIL full_spacing%0d got=%0d exp=%0d", i, rx_t[i] - rx_t[i-1], 10 * CD + 1);
      end
    end
    checks++; if (framing_err != 0) begin failures++; $display("FAIL full_framing got=%0d exp=0", framing_err); end
  endtask

  task automatic test_held_valid();
    logic [31:0] rd;
    int lat;
    rx_q.delete(); rx_t.delete();
    do_access(2'd0, 32'h11, 4'h1, rd, lat);
    idle(1);
    bus.valid = 1'b1; bus.addr = 32'h0; bus.wdata = 32'h5A; bus.wstrb = 4'h1;
    lat = 0;
    do begin idle(1); lat++; end while (bus.ready !== 1'b1 && lat < LAT_MAX);
    checks++; if (lat != 1) begin failures++; $display("FAIL held_first_ready got=%0d exp=1", lat); end
    for (int c = 0; c < 3; c++) begin
      idle(1);
      checks++; if (bus.ready !== 1'b0) begin failures++; $display("FAIL held_no_reaccept cyc=%0d got=%b exp=0", c, bus.ready); end
    end
    bus.valid = 1'b0; bus.wstrb = '0;
    idle(1);
    do_access(2'd1, 32'h0, 4'h0, rd, lat);
    checks++; if (lat != 1) begin failures++; $display("FAIL held_rerise_ready got=%0d exp=1", lat); end
    checks++; if (rd !== 32'h101) begin failures++; $display("FAIL held_status got=%h exp=00000101", rd); end
    idle(2 * (10 * CD + 1) + 20);
    checks++;
    if (rx_q.size() != 2 || rx_q[0] !== 8'h11 || rx_q[1] !== 8'h5A) begin
      failures++;
      $display("FAIL held_rx size=%0d exp 2 bytes 11 5a", rx_q.size());
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] rd;
    int lat;
    rx_q.delete(); rx_t.delete();
    do_access(2'd3, 32'h0, 4'h0, rd, lat);
    checks++; if (rd !== 32'h0 || lat != 1) begin failures++; $display("FAIL unmapped_rd3 got=%h lat=%0d exp=0 lat=1", rd, lat); end
    idle(1);
    do_access(2'd2, 32'h77, 4'hF, rd, lat);
    checks++; if (lat != 1) begin failures++; $display("FAIL unmapped_wr2_lat got=%0d exp=1", lat); end
    idle(1);
    do_access(2'd0, 32'h66, 4'b0010, rd, lat);
    checks++; if (lat != 1) begin failures++; $display("FAIL strobe_lat got=%0d exp=1", lat); end
    idle(1);
    do_access(2'd1, 32'hFF, 4'hF, rd, lat);
    idle(1);
    do_access(2'd0, 32'h0, 4'h0, rd, lat);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL data_read got=%h exp=0", rd); end
    idle(1);
    do_access(2'd1, 32'h0, 4'h0, rd, lat);
    checks++; if (rd !== 32'h4) begin failures++; $display("FAIL unmapped_status got=%h exp=00000004", rd); end
    idle(10 * CD + 10);
    checks++; if (rx_q.size() != 0) begin failures++; $display("FAIL unmapped_rx got=%0d frames exp=0", rx_q.size()); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] rd;
    int lat;
    rx_q.delete(); rx_t.delete();
    do_access(2'd0, 32'h11, 4'h1, rd, lat);
    idle(1);
    do_access(2'd0, 32'h22, 4'h1, rd, lat);
    idle(1);
    do_access(2'd0, 32'h33, 4'h1, rd, lat);
    idle(14);
    rst = 1'b1;
    bus.valid = 1'b1; bus.addr = 32'h0; bus.wdata = 32'h44; bus.wstrb = 4'h1;
    idle(1);
    checks++; if (uart_tx !== 1'b1) begin failures++; $display("FAIL rstmid_tx got=%b exp=1", uart_tx); end
    checks++; if (bus.ready !== 1'b0) begin failures++; $display("FAIL rstmid_ready got=%b exp=0", bus.ready); end
    rst = 1'b0;
    bus.valid = 1'b0; bus.wstrb = '0;
    idle(1);
    rx_q.delete(); rx_t.delete();
    do_access(2'd1, 32'h0, 4'h0, rd, lat);
    checks++; if (rd !== 32'h4) begin failures++; $display("FAIL rstmid_status got=%h exp=00000004", rd); end
    idle(3 * (10 * CD + 1));
    checks++; if (rx_q.size() != 0) begin failures++; $display("FAIL rstmid_rx got=%0d frames exp=0", rx_q.size()); end
  endtask

  initial begin
    bus.valid = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    bus.wstrb = '0;
    #1;
    test_reset();
    test_single_byte();
    test_status_during_tx();
    test_fifo_full();
    test_held_valid();
    test_unmapped();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
